// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//   Control FSM for a multicycle 16-bit datapath. Each instruction walks
//   through fetch, decode, execute, memory and writeback states. The FSM
//   drives the datapath strobes and selects for every cycle, and it waits on
//   memory through MemReady. A wait that lasts too long traps to FAULT.
//
// Parameters
//   WAIT_W       width of the memory-wait counter
//   MEM_TIMEOUT  counter value at which a stalled wait traps to FAULT
//                (0 disables the trap; the counter then saturates)
//
// Ports
//   CLK          in   clock, rising edge
//   Reset        in   asynchronous active-low reset
//   Opcode[3:0]  in   IR[15:12], sampled only in DECODE
//   MemReady     in   memory access completes this cycle
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  conditional PC load (branch)
//   BranchNE     out  1 = bne sense, 0 = beq sense
//   PCSrc[1:0]   out  00 ALU, 01 ALUOut, 10 jump addr, 11 reg A
//   IorD         out  0 PC address, 1 ALUOut address
//   MemRead      out  memory read strobe
//   MemWrite     out  memory write strobe
//   IRWrite      out  IR load
//   ALUSrcA      out  0 PC, 1 reg A
//   ALUSrcB[1:0] out  00 reg B, 01 const 2, 10 sign-ext imm, 11 imm<<1
//   ALUOp[3:0]   out  ALU function code
//   RegWrite     out  register file write
//   MemtoReg[1:0] out 00 ALUOut, 01 MDR, 10 PC (link)
//   Fault        out  sticky memory-timeout flag
//   StateOut[3:0] out current state encoding (debug visibility)
//
// Memory handshake: the FSM holds its request (MemRead or MemWrite, with IorD)
// steady in FETCH / MEM_RD / MEM_WR. The access completes in the cycle that
// samples MemReady=1 at the rising edge. Until then, every cycle with
// MemReady=0 counts as one wait cycle.
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic       Fault,
  output logic [3:0] StateOut
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LOAD_WB  = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;

  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t            state, next_state;
  logic [3:0]        op_q;       // opcode captured in DECODE for later states
  logic [WAIT_W-1:0] wait_cnt;

  logic wait_state;   // state holds a memory request
  logic stalled;      // wait state and memory not ready this cycle
  logic timeout_hit;

  assign wait_state  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign stalled     = wait_state && !MemReady;
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_V);

  // State register, plus the registers that travel with it.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      op_q <= 4'd0;
    end else if (state == S_DECODE) begin
      op_q <= Opcode;
    end
  end

  // The counter is cleared in every cycle that is not a stalled wait. So each
  // entry to FETCH / MEM_RD / MEM_WR starts from zero. On the trap cycle the
  // counter holds, because FAULT never reads it.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wait_cnt <= '0;
    end else if (!stalled) begin
      wait_cnt <= '0;
    end else if (!timeout_hit && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state logic. A completing access (MemReady=1) takes priority over
  // the timeout trap.
  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH: begin
        if (MemReady)         next_state = S_DECODE;
        else if (timeout_hit) next_state = S_FAULT;
      end
      S_DECODE: begin
        unique case (Opcode)
          4'd0, 4'd1, 4'd3, 4'd12, 4'd13: next_state = S_EXEC_R;
          4'd2, 4'd8, 4'd10, 4'd14:       next_state = S_EXEC_I;
          4'd5, 4'd6:                     next_state = S_MEM_ADDR;
          4'd4, 4'd9:                     next_state = S_BRANCH;
          4'd7, 4'd11:                    next_state = S_JUMP;
          4'd15:                          next_state = S_JR;
          default:                        next_state = S_FAULT;
        endcase
      end
      S_EXEC_R:   next_state = S_ALU_WB;
      S_EXEC_I:   next_state = S_ALU_WB;
      S_ALU_WB:   next_state = S_FETCH;
      S_MEM_ADDR: next_state = (op_q == 4'd6) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (MemReady)         next_state = S_LOAD_WB;
        else if (timeout_hit) next_state = S_FAULT;
      end
      S_LOAD_WB:  next_state = S_FETCH;
      S_MEM_WR: begin
        if (MemReady)         next_state = S_FETCH;
        else if (timeout_hit) next_state = S_FAULT;
      end
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_JR:       next_state = S_FETCH;
      S_FAULT:    next_state = S_FAULT;
      default:    next_state = S_FAULT;  // 12-14 are unreachable codes
    endcase
  end

  // Raw outputs before reset gating.
  logic       pc_write, pc_write_cond, branch_ne, ior_d, mem_read, mem_write;
  logic       ir_write, alu_src_a, reg_write, fault;
  logic [1:0] pc_src, alu_src_b, mem_to_reg;
  logic [3:0] alu_op;

  // Output logic. All outputs are Moore, except the FETCH IRWrite/PCWrite
  // pulse, which is qualified by MemReady.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'b00;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 4'b0000;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    fault         = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = MemReady;
        pc_write  = MemReady;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        unique case (op_q)
          4'd1:    alu_op = ALU_SUB;
          4'd3:    alu_op = ALU_SLT;
          4'd12:   alu_op = ALU_AND;
          4'd13:   alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        unique case (op_q)
          4'd8:    alu_op = ALU_SLL;
          4'd10:   alu_op = ALU_SRA;
          4'd14:   alu_op = ALU_SRL;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ior_d    = 1'b1;
        mem_read = 1'b1;
      end
      S_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEM_WR: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        branch_ne     = (op_q == 4'd9);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        if (op_q == 4'd11) begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b10;
        end
      end
      S_JR: begin
        alu_src_a = 1'b1;
        pc_write  = 1'b1;
        pc_src    = 2'b11;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // While Reset is low, every output reads 0 immediately. This happens even
  // before the state register has settled back to FETCH.
  assign PCWrite     = pc_write      & Reset;
  assign PCWriteCond = pc_write_cond & Reset;
  assign BranchNE    = branch_ne     & Reset;
  assign PCSrc       = pc_src        & {2{Reset}};
  assign IorD        = ior_d         & Reset;
  assign MemRead     = mem_read      & Reset;
  assign MemWrite    = mem_write     & Reset;
  assign IRWrite     = ir_write      & Reset;
  assign ALUSrcA     = alu_src_a     & Reset;
  assign ALUSrcB     = alu_src_b     & {2{Reset}};
  assign ALUOp       = alu_op        & {4{Reset}};
  assign RegWrite    = reg_write     & Reset;
  assign MemtoReg    = mem_to_reg    & {2{Reset}};
  assign Fault       = fault         & Reset;
  assign StateOut    = state         & {4{Reset}};

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//   Directed bench for multicycle_sequencer. Each step drives MemReady and
//   Opcode, then pushes the expected full output vector onto exp_q. The vector
//   is popped and compared against the DUT outputs at the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [3:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite;
  logic       IRWrite, ALUSrcA, RegWrite, Fault;
  logic [1:0] PCSrc, ALUSrcB, MemtoReg;
  logic [3:0] ALUOp, StateOut;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  multicycle_sequencer #(.WAIT_W(4), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Fault(Fault), .StateOut(StateOut)
  );

  // clock
  always #5 CLK = ~CLK;

  // Expected-vector builder, field order matches the packing in check().
  function automatic logic [23:0] o(
    input logic [3:0] st, input logic flt, input logic pcw, input logic pcwc,
    input logic bne, input logic [1:0] pcsrc, input logic iord, input logic mrd,
    input logic mwr, input logic irw, input logic srca, input logic [1:0] srcb,
    input logic [3:0] aluop, input logic rw, input logic [1:0] m2r);
    return {st, flt, pcw, pcwc, bne, pcsrc, iord, mrd, mwr, irw, srca, srcb,
            aluop, rw, m2r};
  endfunction

  function automatic logic [23:0] e_fetch(input logic rdy);
    return o(4'd0, 0, rdy, 0, 0, 2'b00, 0, 1, 0, rdy, 0, 2'b01, ADD, 0, 2'b00);
  endfunction

  function automatic logic [23:0] e_decode();
    return o(4'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 2'b00);
  endfunction

  task automatic check(input string tag);
    logic [23:0] got, e;
    got = {StateOut, Fault, PCWrite, PCWriteCond, BranchNE, PCSrc, IorD, MemRead,
           MemWrite, IRWrite, ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg};
    e = exp_q.pop_front();
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, e);
    end
  endtask

  // One clock cycle: drive MemReady, expect e at the falling edge, then step to
  // just after the next rising edge.
  task automatic cyc(input logic mr, input logic [23:0] e, input string tag);
    MemReady = mr;
    exp_q.push_back(e);
    @(negedge CLK);
    check(tag);
    @(posedge CLK);
    #1;
  endtask

  // Fetch and decode an opcode with memory ready. The opcode is scrambled after
  // decode, so that later states must rely on the captured copy.
  task automatic fetch_decode(input logic [3:0] op, input string tag);
    Opcode = op;
    cyc(1'b1, e_fetch(1'b1), {tag, "_fetch"});
    cyc(1'($urandom_range(0, 1)), e_decode(), {tag, "_decode"});
    Opcode = 4'($urandom_range(0, 15));
  endtask

  initial begin
    // reset
    Reset    = 1'b0;
    MemReady = 1'b1;
    Opcode   = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    exp_q.push_back(24'h0);
    check("reset_hold");
    Reset = 1'b1;

    // add: states 0,1,2,4
    fetch_decode(4'd0, "add");
    cyc(1'($urandom_range(0, 1)), o(4'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, ADD, 0, 2'b00), "add_exec");
    cyc(1'($urandom_range(0, 1)), o(4'd4, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b00), "add_wb");

    // slt
    fetch_decode(4'd3, "slt");
    cyc(1'b0, o(4'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 4'b0111, 0, 2'b00), "slt_exec");
    cyc(1'b0, o(4'd4, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b00), "slt_wb");

    // sll immediate
    fetch_decode(4'd8, "sll");
    cyc(1'b1, o(4'd3, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 4'b1001, 0, 2'b00), "sll_exec");
    cyc(1'b1, o(4'd4, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b00), "sll_wb");

    // srl immediate
    fetch_decode(4'd14, "srl");
    cyc(1'b1, o(4'd3, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 4'b1010, 0, 2'b00), "srl_exec");
    cyc(1'b1, o(4'd4, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b00), "srl_wb");

    // load with three stall cycles in MEM_RD: 8 cycles total
    fetch_decode(4'd5, "load");
    cyc(1'b1, o(4'd5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 2'b00), "load_addr");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, o(4'd6, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00), "load_wait");
    cyc(1'b1, o(4'd6, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00), "load_done");
    cyc(1'b0, o(4'd7, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b01), "load_wb");

    // bne then beq
    fetch_decode(4'd9, "bne");
    cyc(1'b1, o(4'd9, 0, 0, 1, 1, 2'b01, 0, 0, 0, 0, 1, 2'b00, SUB, 0, 2'b00), "bne_branch");
    fetch_decode(4'd4, "beq");
    cyc(1'b1, o(4'd9, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 1, 2'b00, SUB, 0, 2'b00), "beq_branch");

    // jal, j, jr
    fetch_decode(4'd11, "jal");
    cyc(1'b0, o(4'd10, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b10), "jal_jump");
    fetch_decode(4'd7, "j");
    cyc(1'b0, o(4'd10, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00), "j_jump");
    fetch_decode(4'd15, "jr");
    cyc(1'b1, o(4'd11, 0, 1, 0, 0, 2'b11, 0, 0, 0, 0, 1, 2'b00, 4'b0000, 0, 2'b00), "jr");

    // store, immediate completion
    fetch_decode(4'd6, "st");
    cyc(1'b0, o(4'd5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 2'b00), "st_addr");
    cyc(1'b1, o(4'd8, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 4'b0000, 0, 2'b00), "st_write");

    // timeout boundary: 15 stalls, then ready on the 16th cycle -> no fault
    Opcode = 4'd7;
    for (int i = 0; i < 15; i++) cyc(1'b0, e_fetch(1'b0), "near_wait");
    cyc(1'b1, e_fetch(1'b1), "near_done");
    cyc(1'b1, e_decode(), "near_decode");
    cyc(1'b1, o(4'd10, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00), "near_jump");

    // timeout: 16 stalled FETCH cycles, then FAULT is held
    for (int i = 0; i < 16; i++) cyc(1'b0, e_fetch(1'b0), "to_wait");
    for (int i = 0; i < 4; i++)
      cyc(1'($urandom_range(0, 1)), o(4'd15, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00), "fault_hold");

    // reset clears FAULT asynchronously
    Reset = 1'b0;
    #1;
    exp_q.push_back(24'h0);
    check("fault_reset");
    @(posedge CLK);
    #1;
    Reset = 1'b1;

    // reset in the middle of a stalled MEM_WR
    fetch_decode(4'd6, "st2");
    cyc(1'b1, o(4'd5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 2'b00), "st2_addr");
    cyc(1'b0, o(4'd8, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 4'b0000, 0, 2'b00), "st2_wait");
    MemReady = 1'b0;
    exp_q.push_back(o(4'd8, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 4'b0000, 0, 2'b00));
    check("st2_before_rst");
    Reset = 1'b0;
    #1;
    exp_q.push_back(24'h0);
    check("st2_async_rst");
    @(posedge CLK);
    #1;
    MemReady = 1'b1;
    exp_q.push_back(24'h0);
    check("st2_rst_held");
    Reset = 1'b1;
    cyc(1'b1, e_fetch(1'b1), "post_rst_fetch");

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_empty got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
